// File: rtl/mmio_bus_router.sv
// rtl/mmio_bus_router.sv - registered one-outstanding MMIO router with region decode, watchdog and error report
module mmio_bus_router #(
  parameter int                 NS       = 4,
  parameter int                 AW       = 16,
  parameter int                 DW       = 16,
  parameter logic [NS*AW-1:0]   BASE     = '0,
  parameter logic [NS*AW-1:0]   LIMIT    = '1,
  parameter logic [NS-1:0]      INSTR_OK = '0,
  parameter int                 TW       = 8,
  parameter int                 TIMEOUT  = 255,
  parameter logic [DW-1:0]      ERR_DATA = 16'hDEAD
) (
  input  logic                 clki,
  input  logic                 rst_in,
  input  logic [AW-1:0]        m_addr,
  input  logic [DW-1:0]        m_wdata,
  input  logic                 m_read,
  input  logic                 m_write,
  input  logic                 m_instr,
  output logic [DW-1:0]        m_rdata,
  output logic                 m_busy,
  output logic                 m_ready,
  output logic                 m_read_done,
  output logic                 m_err,
  output logic [AW-1:0]        s_addr,
  output logic [DW-1:0]        s_wdata,
  output logic [NS-1:0]        s_read,
  output logic [NS-1:0]        s_write,
  input  logic [NS*DW-1:0]     s_rdata,
  input  logic [NS-1:0]        s_busy,
  input  logic [NS-1:0]        s_ready,
  output logic                 err_sticky,
  output logic [AW-1:0]        err_addr,
  input  logic                 err_clr
);

  localparam int SW = (NS > 1) ? $clog2(NS) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR_RESP} state_t;

  state_t          state;
  logic [SW-1:0]   sel;
  logic            is_read;
  logic [AW-1:0]   lat_addr;
  logic [TW-1:0]   cnt;

  logic            hit;
  logic [SW-1:0]   hit_idx;
  logic [AW-1:0]   hit_base;

  // s_busy is observed by the slaves' owners only; it never steers routing.
  logic unused_s_busy;
  assign unused_s_busy = ^s_busy;

  // Scan from the top down so the lowest matching index wins on overlap.
  always_comb begin
    hit      = 1'b0;
    hit_idx  = '0;
    hit_base = '0;
    for (int i = NS - 1; i >= 0; i--) begin
      if (m_addr >= BASE[i*AW +: AW] && m_addr <= LIMIT[i*AW +: AW] &&
          (!m_instr || INSTR_OK[i])) begin
        hit      = 1'b1;
        hit_idx  = SW'(i);
        hit_base = BASE[i*AW +: AW];
      end
    end
  end

  always_ff @(posedge clki or negedge rst_in) begin
    if (!rst_in) begin
      state       <= IDLE;
      sel         <= '0;
      is_read     <= 1'b0;
      lat_addr    <= '0;
      cnt         <= '0;
      m_rdata     <= '0;
      m_busy      <= 1'b0;
      m_ready     <= 1'b0;
      m_read_done <= 1'b0;
      m_err       <= 1'b0;
      s_addr      <= '0;
      s_wdata     <= '0;
      s_read      <= '0;
      s_write     <= '0;
      err_sticky  <= 1'b0;
      err_addr    <= '0;
    end else begin
      m_ready     <= 1'b0;
      m_read_done <= 1'b0;
      m_err       <= 1'b0;
      m_rdata     <= '0;
      if (err_clr)
        err_sticky <= 1'b0;

      case (state)
        IDLE: begin
          m_busy <= 1'b0;
          if (m_read || m_write) begin
            m_busy   <= 1'b1;
            is_read  <= !m_write;
            lat_addr <= m_addr;
            if (hit) begin
              sel     <= hit_idx;
              s_addr  <= m_addr - hit_base;
              s_wdata <= m_wdata;
              cnt     <= '0;
              if (m_write)
                s_write <= NS'(1) << hit_idx;
              else
                s_read  <= NS'(1) << hit_idx;
              state <= ACTIVE;
            end else begin
              err_addr <= m_addr;
              state    <= ERR_RESP;
            end
          end
        end

        ACTIVE: begin
          if (s_ready[sel]) begin
            m_ready     <= 1'b1;
            m_read_done <= is_read;
            m_rdata     <= s_rdata[sel*DW +: DW];
            s_read      <= '0;
            s_write     <= '0;
            state       <= IDLE;
          end else if (TIMEOUT != 0 && cnt == TO_LAST) begin
            s_read   <= '0;
            s_write  <= '0;
            err_addr <= lat_addr;
            state    <= ERR_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ERR_RESP: begin
          m_ready     <= 1'b1;
          m_err       <= 1'b1;
          m_read_done <= is_read;
          m_rdata     <= ERR_DATA;
          err_sticky  <= 1'b1;
          state       <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mmio_bus_router.md
Name: mmio_bus_router

Overview:
- Parametrised memory-mapped bus router between the CPU data/instruction port and NS slave devices (SDRAM, VGA, UART, IO registers).
- Replaces the combinational address-switch with a registered, one-outstanding-transaction router.
- Adds per-region base/limit decode, per-region instruction-fetch permission, slave-relative addressing, a timeout watchdog and a sticky error report.

Parameters:
- NS, 4, number of slave regions (1..8).
- AW, 16, address width.
- DW, 16, data width.
- BASE, {NS*AW}, flat vector; region i base at bits [i*AW +: AW].
- LIMIT, {NS*AW}, flat vector; region i inclusive limit at bits [i*AW +: AW].
- INSTR_OK, {NS{1'b0}}, bit i=1: region i accepts instruction fetches (m_instr=1).
- TW, 8, timeout counter width.
- TIMEOUT, 255, cycles allowed in ACTIVE before abort; 0 disables the watchdog.
- ERR_DATA, 16'hDEAD, read data returned on an error response.

Ports:
- clki  in  1  clock, all state on rising edge.
- rst_in  in  1  asynchronous active-low reset.
- m_addr  in  AW  master address.
- m_wdata  in  DW  master write data.
- m_read  in  1  master read request, held until m_ready.
- m_write  in  1  master write request, held until m_ready.
- m_instr  in  1  request is an instruction fetch.
- m_rdata  out  DW  read data, valid while m_ready=1.
- m_busy  out  1  transaction in progress.
- m_ready  out  1  one-cycle completion pulse.
- m_read_done  out  1  one-cycle pulse, equal to m_ready & the latched read type.
- m_err  out  1  completing transaction failed (coincides with m_ready).
- s_addr  out  AW  latched m_addr minus BASE of the selected region.
- s_wdata  out  DW  latched write data, broadcast to all slaves.
- s_read  out  NS  one-hot read strobe.
- s_write  out  NS  one-hot write strobe.
- s_rdata  in  NS*DW  flat slave read data.
- s_busy  in  NS  slave busy (monitor only, not used for routing).
- s_ready  in  NS  slave completion.
- err_sticky  out  1  set on any error; cleared by err_clr.
- err_addr  out  AW  m_addr of the most recent error.
- err_clr  in  1  clears err_sticky.

Behaviour:
- States: IDLE, ACTIVE, ERR_RESP.

Reset (rst_in=0, asynchronous):
- State IDLE; all outputs 0, including err_addr and err_sticky.
- Any in-flight slave strobe drops immediately; the aborted transaction gets no m_ready.

IDLE:
- On m_read|m_write, decode the region: lowest index i with BASE_i <= m_addr <= LIMIT_i, and (m_instr=0 or INSTR_OK[i]=1).
- Hit: latch sel=i, type, s_addr, s_wdata. Next state ACTIVE.
- Miss: latch err_addr=m_addr. Next state ERR_RESP.
- m_read and m_write both high: treated as a write.

ACTIVE:
- s_read[sel] or s_write[sel] held high, m_busy=1, timeout counter increments from 0.
- On s_ready[sel]=1 at cycle C:
  - At C+1: m_ready=1; m_rdata = s_rdata[sel], captured at C.
  - Strobes drop at C+1; state returns to IDLE.
- If TIMEOUT!=0 and the counter reaches TIMEOUT-1 without s_ready:
  - Strobes drop, err_addr latched, next state ERR_RESP.
- s_ready arriving on the timeout cycle wins; no error is raised.
- s_ready from non-selected slaves is ignored.

ERR_RESP (one cycle):
- m_ready=1, m_err=1, m_rdata=ERR_DATA, err_sticky set; then IDLE.

Latency and handshake:
- Best case: request at cycle N, strobe at N+1, s_ready at N+1, m_ready at N+2.
- m_busy=1 from N+1 until the m_ready cycle inclusive.
- New requests are only sampled in IDLE. The master must deassert within the m_ready cycle, otherwise the request is re-issued.

Other rules:
- err_clr and an error in the same cycle: set wins.
- m_rdata=0 whenever m_ready=0.
- Address compare is unsigned; s_addr subtraction is modulo 2^AW.

Test Plan:
- Map r0=0000-0FFF, r1=1000-4BFF, r2=4C00-FFFF (INSTR_OK=100). Write 1234 to 1005; r1 asserts s_ready 2 cycles later -> s_write=0010, s_addr=0005, m_ready exactly 1 cycle, m_err=0.
- Read 4C10 with r2 returning BEEF -> m_rdata=BEEF with m_ready, m_read_done pulses, s_addr=0010.
- Instruction fetch from 0200 (r0, INSTR_OK=0) -> no slave strobe, m_ready+m_err at N+2, m_rdata=DEAD, err_sticky=1, err_addr=0200. err_clr -> err_sticky=0.
- TIMEOUT=4, r1 never ready -> strobe high for exactly 4 cycles, then ERR_RESP. A variant with s_ready on the 4th cycle completes normally.
- Overlapping regions r0=0000-0FFF, r1=0800-1FFF, access 0900 -> r0 selected (lowest index).
- Assert rst_in=0 mid-ACTIVE -> all strobes and m_busy 0 in the same cycle, no m_ready; the next request after release works normally.
